// File: rtl/miriscv_rvfi_serializer_pkg.sv
// RVFI retirement record layout shared by the serializer, its interface and benches.
// XLEN is fixed at 32; lane unpacking supports up to MAX_LANES retirement lanes.
package miriscv_rvfi_pkg;

  localparam int XLEN      = 32;
  localparam int MAX_LANES = 8;

  typedef struct packed {
    logic [63:0]     order;
    logic [31:0]     insn;
    logic            trap;
    logic            halt;
    logic            intr;
    logic [1:0]      mode;
    logic [1:0]      ixl;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_rmask;
    logic [3:0]      mem_wmask;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
  } rvfi_rec_t;

  localparam int REC_W = $bits(rvfi_rec_t);

  // Callers zero-pad their NRET*REC_W vector up to MAX_LANES lanes before calling.
  function automatic rvfi_rec_t lane_rec(input logic [MAX_LANES*REC_W-1:0] flat, input int k);
    return flat[k*REC_W +: REC_W];
  endfunction

endpackage

// File: rtl/miriscv_rvfi_serializer_if.sv
// Multi-lane RVFI input, single-stream output and status bundle of the serializer.
interface miriscv_rvfi_serializer_if
  import miriscv_rvfi_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 8
) ();

  logic                       flush_i;
  logic [NRET-1:0]            rvfi_valid_i;
  logic [NRET*REC_W-1:0]      rvfi_rec_i;
  logic                       in_ready_o;
  logic                       out_valid_o;
  rvfi_rec_t                  out_rec_o;
  logic                       out_ready_i;
  logic [$clog2(DEPTH):0]     count_o;
  logic                       order_err_o;
  logic [15:0]                drop_cnt_o;

  modport master (
    output flush_i, rvfi_valid_i, rvfi_rec_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_rec_o, count_o, order_err_o, drop_cnt_o
  );

  modport slave (
    input  flush_i, rvfi_valid_i, rvfi_rec_i, out_ready_i,
    output in_ready_o, out_valid_o, out_rec_o, count_o, order_err_o, drop_cnt_o
  );

endinterface

// File: rtl/miriscv_rvfi_lane_compact.sv
// Prefix popcount over the lane valid mask: per-lane write offset and total push count.
module miriscv_rvfi_lane_compact #(
  parameter int NRET = 2,
  parameter int LW   = $clog2(NRET + 1)
) (
  input  logic [NRET-1:0]         valid,
  output logic [NRET-1:0][LW-1:0] offset,
  output logic [LW-1:0]           total
);

  logic [LW-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int k = 0; k < NRET; k++) begin
      offset[k] = acc;
      acc       = acc + LW'(valid[k]);
    end
    total = acc;
  end

endmodule

// File: rtl/miriscv_rvfi_serializer.sv
// Packs up to NRET retirement records per cycle into a FIFO and drains them one per cycle,
// checking order continuity on the output side and counting records lost to overflow.
module miriscv_rvfi_serializer
  import miriscv_rvfi_pkg::*;
#(
  parameter int NRET        = 2,
  parameter int DEPTH       = 8,
  parameter int CHECK_ORDER = 1
) (
  input logic                     clk,
  input logic                     arstn,
  miriscv_rvfi_serializer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int LW = $clog2(NRET + 1);

  rvfi_rec_t                  mem [DEPTH];
  logic [PW-1:0]              wr_ptr_reg;
  logic [PW-1:0]              rd_ptr_reg;
  logic [CW-1:0]              count_reg;
  logic [15:0]                drop_cnt_reg;
  logic                       order_err_reg;

  logic [NRET-1:0][LW-1:0]    lane_offset;
  logic [LW-1:0]              push_total;
  logic [LW-1:0]              push_cnt;
  logic                       in_ready;
  logic                       out_valid;
  logic                       push_en;
  logic                       pop_en;
  logic [16:0]                drop_sum;
  rvfi_rec_t                  head_rec;
  logic [MAX_LANES*REC_W-1:0] rec_flat;

  miriscv_rvfi_lane_compact #(
    .NRET (NRET),
    .LW   (LW)
  ) u_compact (
    .valid  (bus.rvfi_valid_i),
    .offset (lane_offset),
    .total  (push_total)
  );

  // Space is judged on the registered count only; a same-cycle pop never frees room.
  assign in_ready  = count_reg <= CW'(DEPTH - NRET);
  assign out_valid = count_reg != '0;
  assign push_en   = in_ready & ~bus.flush_i;
  assign pop_en    = out_valid & bus.out_ready_i & ~bus.flush_i;
  assign push_cnt  = push_en ? push_total : '0;
  assign drop_sum  = {1'b0, drop_cnt_reg} + 17'(push_total);
  assign head_rec  = mem[rd_ptr_reg];

  always_comb begin
    rec_flat                  = '0;
    rec_flat[NRET*REC_W-1:0]  = bus.rvfi_rec_i;
  end

  // Storage is deliberately unreset; the head is read combinationally for fall-through.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NRET; k++) begin
      if (push_en && bus.rvfi_valid_i[k]) begin
        mem[wr_ptr_reg + PW'(lane_offset[k])] <= lane_rec(rec_flat, k);
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(push_cnt);
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + CW'(push_cnt) - CW'(pop_en);
    end
  end

  // Drop counter survives flush so overflow history stays visible to the consumer.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      drop_cnt_reg <= '0;
    end else if (!in_ready && !bus.flush_i) begin
      drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  generate
    if (CHECK_ORDER != 0) begin : g_order
      logic [63:0] exp_order_reg;

      // Expected order always resyncs to the popped record, so one gap flags once.
      always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
          exp_order_reg <= '0;
          order_err_reg <= 1'b0;
        end else if (bus.flush_i) begin
          exp_order_reg <= '0;
          order_err_reg <= 1'b0;
        end else if (pop_en) begin
          exp_order_reg <= head_rec.order + 64'd1;
          if (head_rec.order != exp_order_reg) begin
            order_err_reg <= 1'b1;
          end
        end
      end
    end else begin : g_no_order
      assign order_err_reg = 1'b0;
    end
  endgenerate

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_rec_o   = out_valid ? head_rec : '0;
  assign bus.count_o     = count_reg;
  assign bus.order_err_o = order_err_reg;
  assign bus.drop_cnt_o  = drop_cnt_reg;

endmodule

// File: tb/tb_miriscv_rvfi_serializer.sv
// Scoreboard bench: the driver queues accepted records, a negedge monitor pops and compares.
module tb_miriscv_rvfi_serializer;
  import miriscv_rvfi_pkg::*;

  localparam int NRET  = 2;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic arstn = 1'b1;
  always #5 clk = ~clk;

  miriscv_rvfi_serializer_if #(.NRET(NRET), .DEPTH(DEPTH)) bus ();

  miriscv_rvfi_serializer #(
    .NRET        (NRET),
    .DEPTH       (DEPTH),
    .CHECK_ORDER (1)
  ) dut (
    .clk   (clk),
    .arstn (arstn),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  rvfi_rec_t   exp_q[$];
  int          exp_count;
  logic        exp_in_ready;
  logic [15:0] snap_drop;
  int          model_drop;
  logic        model_err;
  logic [63:0] model_exp;
  logic        pending_flush;
  logic [63:0] next_order;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic rvfi_rec_t make_rec(input logic [63:0] ord);
    logic [REC_W+31:0] bits_v;
    rvfi_rec_t r;
    for (int i = 0; i < REC_W; i += 32) bits_v[i +: 32] = $urandom;
    r       = bits_v[REC_W-1:0];
    r.order = ord;
    return r;
  endfunction

  // One clock of stimulus; the model state at entry equals the DUT state for this cycle.
  task automatic cycle(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                       input logic fl, input logic rdy);
    rvfi_rec_t r0, r1;
    @(posedge clk);
    #1;
    if (pending_flush) begin
      exp_q.delete();
      model_err     = 1'b0;
      model_exp     = '0;
      pending_flush = 1'b0;
    end
    exp_count    = exp_q.size();
    exp_in_ready = (DEPTH - exp_count) >= NRET;
    snap_drop    = model_drop[15:0];
    r0 = make_rec(o0);
    r1 = make_rec(o1);
    bus.rvfi_valid_i = v;
    bus.rvfi_rec_i   = {r1, r0};
    bus.flush_i      = fl;
    bus.out_ready_i  = rdy;
    if (fl) begin
      pending_flush = 1'b1;
    end else if (exp_in_ready) begin
      if (v[0]) exp_q.push_back(r0);
      if (v[1]) exp_q.push_back(r1);
    end else begin
      model_drop += int'(v[0]) + int'(v[1]);
      if (model_drop > 65535) model_drop = 65535;
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(2'b00, 64'd0, 64'd0, 1'b0, rdy);
  endtask

  task automatic push_seq(input logic rdy);
    logic [1:0] v;
    logic [63:0] o0, o1;
    v  = 2'($urandom_range(0, 3));
    o0 = next_order;
    if (v[0]) next_order++;
    o1 = next_order;
    if (v[1]) next_order++;
    cycle(v, o0, o1, 1'b0, rdy);
  endtask

  always @(negedge clk) begin
    rvfi_rec_t h;
    if (arstn) begin
      check("count", 64'(bus.count_o), 64'(exp_count));
      check("in_ready", 64'(bus.in_ready_o), 64'(exp_in_ready));
      check("out_valid", 64'(bus.out_valid_o), 64'(exp_count != 0));
      check("order_err", 64'(bus.order_err_o), 64'(model_err));
      check("drop_cnt", 64'(bus.drop_cnt_o), 64'(snap_drop));
      if (exp_count != 0 && bus.out_ready_i && !bus.flush_i) begin
        h = exp_q.pop_front();
        checks++;
        if (bus.out_rec_o !== h) begin
          errors++;
          $display("FAIL out_rec actual order=%0d pc=%h required order=%0d pc=%h",
                   bus.out_rec_o.order, bus.out_rec_o.pc_rdata, h.order, h.pc_rdata);
        end else begin
          $display("pop order=%0d pc=%h", h.order, h.pc_rdata);
        end
        if (h.order != model_exp) model_err = 1'b1;
        model_exp = h.order + 64'd1;
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    model_drop    = 0;
    snap_drop     = '0;
    model_err     = 1'b0;
    model_exp     = '0;
    pending_flush = 1'b0;
    exp_count     = 0;
    exp_in_ready  = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check("rst_count", 64'(bus.count_o), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    check("rst_order_err", 64'(bus.order_err_o), 64'd0);
    check("rst_drop_cnt", 64'(bus.drop_cnt_o), 64'd0);
    checks++;
    if (bus.out_rec_o !== '0) begin
      errors++;
      $display("FAIL rst_out_rec actual order=%0d required 0", bus.out_rec_o.order);
    end
  endtask

  initial begin
    bus.flush_i      = 1'b0;
    bus.rvfi_valid_i = '0;
    bus.rvfi_rec_i   = '0;
    bus.out_ready_i  = 1'b0;
    clear_model();
    next_order = '0;
    #2 arstn = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 arstn = 1'b1;

    // Both lanes, orders 0/1, consumer always ready
    cycle(2'b11, 64'd0, 64'd1, 1'b0, 1'b1);
    idle(2, 1'b1);
    // Orders 2..4, then lane 1 alone carrying order 5
    cycle(2'b11, 64'd2, 64'd3, 1'b0, 1'b1);
    cycle(2'b01, 64'd4, 64'hDEAD, 1'b0, 1'b1);
    cycle(2'b10, 64'hBEEF, 64'd5, 1'b0, 1'b1);
    idle(3, 1'b1);
    // Fill with the consumer stalled, then overflow by one pair
    for (int i = 0; i < 4; i++) cycle(2'b11, 64'(6 + 2*i), 64'(7 + 2*i), 1'b0, 1'b0);
    cycle(2'b11, 64'd14, 64'd15, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(9, 1'b1);
    // Order gap: 14,15 then 17,18 flags once on 17
    cycle(2'b11, 64'd14, 64'd15, 1'b0, 1'b1);
    cycle(2'b11, 64'd17, 64'd18, 1'b0, 1'b1);
    idle(5, 1'b1);
    // Refill, then flush a full FIFO; drop count must survive
    for (int i = 0; i < 4; i++) cycle(2'b11, 64'(19 + 2*i), 64'(20 + 2*i), 1'b0, 1'b0);
    idle(1, 1'b0);
    cycle(2'b11, 64'd40, 64'd41, 1'b1, 1'b1);
    idle(1, 1'b1);
    cycle(2'b01, 64'd0, 64'd0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Randomised traffic with occasional flushes
    next_order = 64'd1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        cycle(2'b00, 64'd0, 64'd0, 1'b1, 1'b1);
        next_order = '0;
      end else begin
        push_seq(($urandom_range(0, 3) != 0));
      end
    end
    idle(DEPTH + 2, 1'b1);

    // Reach count 5 with the consumer stalled, then reset asynchronously
    cycle(2'b11, 64'd100, 64'd101, 1'b0, 1'b0);
    cycle(2'b11, 64'd102, 64'd103, 1'b0, 1'b0);
    cycle(2'b01, 64'd104, 64'd0, 1'b0, 1'b0);
    idle(1, 1'b0);
    @(posedge clk);
    #3;
    bus.rvfi_valid_i = '0;
    arstn = 1'b0;
    #1 check_reset_outputs();
    clear_model();
    @(posedge clk);
    #1 arstn = 1'b1;

    // Sustained push/pop across several pointer wraps
    next_order = '0;
    for (int i = 0; i < 3*DEPTH + 4; i++) begin
      cycle(2'b01, next_order, 64'd0, 1'b0, 1'b1);
      next_order++;
    end
    idle(3, 1'b1);

    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
